mmss_counter_ctl: RTL and testbench

- Sequencer for a 4-digit mixed-radix up/down counter built from four chained Inc_Dec digit cells, one per digit.
- Per digit radix is R0..R3; the default MM:SS layout is 10,6,10,6.
- Provides run/pause/clear/load control, a tick-qualified step, and carry/borrow ripple between digits.
- Drives the display path on the BASYS3 board.

---
 rtl/mmss_counter_ctl.sv | 137 +++++++++++++
 tb/tb_mmss_counter_ctl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mmss_counter_ctl.sv
// mmss_counter_ctl: run/pause/clear/load sequencer over four chained mixed-radix Inc_Dec digit cells.
// Optional build macro MMSS_STOP_AT_ZERO_EN: a down count that lands on zero stops in DONE.

module mmss_incdec #(
    parameter int R = 10
) (
    input  logic [3:0] q,
    input  logic       en,
    input  logic       dn,
    output logic [3:0] nq,
    output logic       term
);
    localparam logic [3:0] QMAX = 4'(R - 1);

    // term: this digit is at the boundary that passes a carry/borrow upward
    always_comb begin
        term = dn ? (q == 4'd0) : (q == QMAX);
        nq   = q;
        if (en) begin
            if (dn) nq = (q == 4'd0) ? QMAX : q - 4'd1;
            else    nq = (q == QMAX) ? 4'd0 : q + 4'd1;
        end
    end
endmodule

module mmss_counter_ctl #(
    parameter int R0 = 10,
    parameter int R1 = 6,
    parameter int R2 = 10,
    parameter int R3 = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        dir,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] digits,
    output logic        running,
    output logic        done,
    output logic        wrap
);
    localparam int RADIX [4] = '{R0, R1, R2, R3};

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] digits_nxt, step_val, load_clamped;
    logic [4:0]  chain;
    logic [3:0]  term;
    logic        wrap_nxt, step;

    assign chain[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dig
            localparam logic [3:0] QMAX = 4'(RADIX[g] - 1);
            mmss_incdec #(.R(RADIX[g])) u_dig (
                .q   (digits[4*g +: 4]),
                .en  (chain[g]),
                .dn  (dir),
                .nq  (step_val[4*g +: 4]),
                .term(term[g])
            );
            assign chain[g+1] = chain[g] & term[g];
            assign load_clamped[4*g +: 4] =
                (load_val[4*g +: 4] > QMAX) ? QMAX : load_val[4*g +: 4];
        end
    endgenerate

    // chain[4]: every digit at its boundary, i.e. this step wraps the whole counter
    assign step = tick && (state == RUN) && !clear && !load && !stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            digits <= 16'h0000;
            wrap   <= 1'b0;
        end else begin
            state  <= state_nxt;
            digits <= digits_nxt;
            wrap   <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear || load) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, PAUSE: if (!stop && start) state_nxt = RUN;
                RUN: begin
                    if (stop) state_nxt = PAUSE;
`ifdef MMSS_STOP_AT_ZERO_EN
                    else if (step && dir && (chain[4] || step_val == 16'h0000))
                        state_nxt = DONE;
`endif
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        digits_nxt = digits;
        wrap_nxt   = 1'b0;
        if (clear) begin
            digits_nxt = 16'h0000;
        end else if (load) begin
            digits_nxt = load_clamped;
        end else if (step) begin
`ifdef MMSS_STOP_AT_ZERO_EN
            // down-wrap is suppressed: zero holds and DONE is entered instead
            if (!(dir && chain[4])) begin
                digits_nxt = step_val;
                wrap_nxt   = chain[4] & ~dir;
            end
`else
            digits_nxt = step_val;
            wrap_nxt   = chain[4];
`endif
        end
    end

    assign running = (state == RUN);
`ifdef MMSS_STOP_AT_ZERO_EN
    assign done = (state == DONE);
`else
    assign done = 1'b0;
`endif
endmodule

// File: tb/tb_mmss_counter_ctl.sv
// Scoreboard bench for mmss_counter_ctl: expectations queued at drive time, checked one edge later.

module tb_mmss_counter_ctl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 0, start = 0, stop = 0, clear = 0, dir = 0, load = 0;
    logic [15:0] load_val = 16'h0;
    logic [15:0] digits;
    logic        running, done, wrap;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [15:0] d;
        logic        run;
        logic        wr;
        logic        dn;
    } exp_t;

    exp_t sb[$];

    mmss_counter_ctl dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .dir(dir), .load(load), .load_val(load_val),
        .digits(digits), .running(running), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".digits"},  32'(digits),  32'(e.d));
            chk({e.tag, ".running"}, 32'(running), 32'(e.run));
            chk({e.tag, ".wrap"},    32'(wrap),    32'(e.wr));
            chk({e.tag, ".done"},    32'(done),    32'(e.dn));
        end
    end

    // ctl = {clear, load, stop, start, tick, dir}
    task automatic drive(input string tag, input logic [5:0] ctl, input logic [15:0] lv,
                         input logic [15:0] ed, input logic er, input logic ew, input logic edn);
        exp_t e;
        @(negedge clk);
        {clear, load, stop, start, tick, dir} = ctl;
        load_val = lv;
        e.tag = tag; e.d = ed; e.run = er; e.wr = ew; e.dn = edn;
        sb.push_back(e);
    endtask

    localparam logic [5:0] NONE = 6'b000000, TICK = 6'b000010, TICKD = 6'b000011,
                           START = 6'b000100, LOAD = 6'b010000, CLEAR = 6'b100000,
                           STOP = 6'b001000;

    initial begin
        #1;
        chk("rst.digits", 32'(digits), 32'h0);
        chk("rst.running", 32'(running), 32'h0);
        chk("rst.done", 32'(done), 32'h0);
        chk("rst.wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // async reset mid-cycle
        drive("pre_load",  LOAD,  16'h0122, 16'h0122, 0, 0, 0);
        drive("pre_start", START, 16'h0,    16'h0122, 1, 0, 0);
        drive("pre_tick",  TICK,  16'h0,    16'h0123, 1, 0, 0);
        @(posedge clk); #3;
        {clear, load, stop, start, tick, dir} = NONE;
        rst_n = 1'b0;
        #1;
        chk("arst.digits", 32'(digits), 32'h0);
        chk("arst.running", 32'(running), 32'h0);
        chk("arst.wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive("idle_tick", TICK, 16'h0, 16'h0000, 0, 0, 0);

        // up ripple and full wrap
        drive("up_load",  LOAD,  16'h0959, 16'h0959, 0, 0, 0);
        drive("up_start", START, 16'h0,    16'h0959, 1, 0, 0);
        drive("up_tick",  TICK,  16'h0,    16'h1000, 1, 0, 0);
        drive("wr_load",  LOAD,  16'h5959, 16'h5959, 0, 0, 0);
        drive("wr_start", START, 16'h0,    16'h5959, 1, 0, 0);
        drive("wr_tick",  TICK,  16'h0,    16'h0000, 1, 1, 0);
        drive("wr_after", NONE,  16'h0,    16'h0000, 1, 0, 0);

        // down borrow, dir change between ticks
        drive("dn_load",  LOAD,  16'h1000, 16'h1000, 0, 0, 0);
        drive("dn_start", START, 16'h0,    16'h1000, 1, 0, 0);
        drive("dn_tick1", TICKD, 16'h0,    16'h0959, 1, 0, 0);
        drive("dn_tick2", TICKD, 16'h0,    16'h0958, 1, 0, 0);
        drive("dir_up",   TICK,  16'h0,    16'h0959, 1, 0, 0);

        // zero boundary
        drive("z_load",  LOAD,  16'h0001, 16'h0001, 0, 0, 0);
        drive("z_start", START, 16'h0,    16'h0001, 1, 0, 0);
`ifdef MMSS_STOP_AT_ZERO_EN
        drive("z_tick",  TICKD, 16'h0,    16'h0000, 0, 0, 1);
        drive("z_tick2", TICKD, 16'h0,    16'h0000, 0, 0, 1);
        drive("z_tick3", TICKD, 16'h0,    16'h0000, 0, 0, 1);
        drive("z_tick4", TICK,  16'h0,    16'h0000, 0, 0, 1);
        drive("z_clear", CLEAR, 16'h0,    16'h0000, 0, 0, 0);
`else
        drive("z_tick",  TICKD, 16'h0,    16'h0000, 1, 0, 0);
        drive("z_wrap",  TICKD, 16'h0,    16'h5959, 1, 1, 0);
        drive("z_after", NONE,  16'h0,    16'h5959, 1, 0, 0);
        drive("z_clear", CLEAR, 16'h0,    16'h0000, 0, 0, 0);
`endif

        // priority
        drive("p_load",   LOAD,         16'h0005, 16'h0005, 0, 0, 0);
        drive("p_start",  START,        16'h0,    16'h0005, 1, 0, 0);
        drive("p_clrtk",  CLEAR | TICK, 16'h0,    16'h0000, 0, 0, 0);
        drive("p_load2",  LOAD,         16'h0005, 16'h0005, 0, 0, 0);
        drive("p_start2", START,        16'h0,    16'h0005, 1, 0, 0);
        drive("p_stoptk", STOP | TICK,  16'h0,    16'h0005, 0, 0, 0);
        drive("p_pausetk", TICK,        16'h0,    16'h0005, 0, 0, 0);
        drive("p_starttk", START | TICK, 16'h0,   16'h0005, 1, 0, 0);
        drive("p_tick",   TICK,         16'h0,    16'h0006, 1, 0, 0);

        // load clamp and load during RUN
        drive("c_load",  LOAD,  16'h7F9A, 16'h5959, 0, 0, 0);
        drive("c_loadf", LOAD,  16'hFFFF, 16'h5959, 0, 0, 0);
        drive("c_start", START, 16'h0,    16'h5959, 1, 0, 0);
        drive("c_runld", LOAD | TICK, 16'h1234, 16'h1234, 0, 0, 0);
        drive("c_idletk", TICK, 16'h0,    16'h1234, 0, 0, 0);

        @(negedge clk);
        {clear, load, stop, start, tick, dir} = NONE;
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
